// File: rtl/gen_nonlinear_seq_pkg.sv
// ============================================================================
// Module : gen_nonlinear_seq_pkg
// Brief  : Shared widths, group offsets and FSM state type for the
//          non-linear carry-term sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gen_nonlinear_seq_pkg;

  localparam int NL_W      = 25;
  localparam int NL_G1_OFF = 0;
  localparam int NL_G2_OFF = 3;
  localparam int NL_G3_OFF = 10;
  localparam int NL_G1_W   = 3;
  localparam int NL_G2_W   = 7;
  localparam int NL_G3_W   = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_G1   = 3'd1,
    ST_G2   = 3'd2,
    ST_G3   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gen_nonlinear_seq_if.sv
// ============================================================================
// Module : gen_nonlinear_seq_if
// Brief  : Operand-in / carry-terms-out handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gen_nonlinear_seq_if;
  import gen_nonlinear_seq_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      a;
  logic [3:0]      b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [NL_W-1:0] n_out;
  logic [3:0]      a_out;
  logic [3:0]      b_out;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, n_out, a_out, b_out
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, n_out, a_out, b_out
  );

endinterface

`default_nettype wire

// File: rtl/gen_nonlinear_seq_group.sv
// ============================================================================
// Module : gen_nl_group
// Brief  : One group of carry product terms: {b_i&prev, a_i&prev, a_i&b_i}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gen_nl_group #(
  parameter int W = 1
) (
  input  logic           a_i,
  input  logic           b_i,
  input  logic [W-1:0]   prev,
  output logic [2*W:0]   grp
);

  assign grp = {({W{b_i}} & prev), ({W{a_i}} & prev), (a_i & b_i)};

endmodule

`default_nettype wire

// File: rtl/gen_nonlinear_seq.sv
// ============================================================================
// Module : gen_nonlinear_seq
// Brief  : Builds the 25 non-linear carry terms of a 4-bit add over three
//          registered groups. Define GEN_NL_CARRY_IN_EN to honour cin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gen_nonlinear_seq
  import gen_nonlinear_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  gen_nonlinear_seq_if.slave bus
);

  state_t          state_q, state_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic            cin_q, cin_d;
  logic [NL_W-1:0] n_q, n_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic               w_accept;
  logic               w_cin_sel;
  logic [NL_G1_W-1:0] w_g1;
  logic [NL_G2_W-1:0] w_g2;
  logic [NL_G3_W-1:0] w_g3;

`ifdef GEN_NL_CARRY_IN_EN
  assign w_cin_sel = bus.cin;
`else
  logic w_unused_cin;
  assign w_unused_cin = bus.cin;
  assign w_cin_sel    = 1'b0;
`endif

  assign w_accept = bus.in_valid & in_ready_q;

  // Each group reads only registered terms of the group before it.
  gen_nl_group #(.W(1)) u_g1 (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .prev(cin_q),
    .grp (w_g1)
  );

  gen_nl_group #(.W(NL_G1_W)) u_g2 (
    .a_i (a_q[1]),
    .b_i (b_q[1]),
    .prev(n_q[NL_G1_OFF +: NL_G1_W]),
    .grp (w_g2)
  );

  gen_nl_group #(.W(NL_G2_W)) u_g3 (
    .a_i (a_q[2]),
    .b_i (b_q[2]),
    .prev(n_q[NL_G2_OFF +: NL_G2_W]),
    .grp (w_g3)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cin_d   = w_cin_sel;
          n_d     = '0;
          state_d = ST_G1;
        end
      end
      ST_G1: begin
        n_d[NL_G1_OFF +: NL_G1_W] = w_g1;
        state_d                   = ST_G2;
      end
      ST_G2: begin
        n_d[NL_G2_OFF +: NL_G2_W] = w_g2;
        state_d                   = ST_G3;
      end
      ST_G3: begin
        n_d[NL_G3_OFF +: NL_G3_W] = w_g3;
        state_d                   = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake flags are registered from the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      n_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.n_out     = n_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;

endmodule

`default_nettype wire

// File: tb/tb_gen_nonlinear_seq.sv
// ============================================================================
// Module : tb_gen_nonlinear_seq
// Brief  : Directed and random self-checking bench for gen_nonlinear_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gen_nonlinear_seq;

`ifdef GEN_NL_CARRY_IN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gen_nonlinear_seq_if bus ();

  gen_nonlinear_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Sum bits 3..1 rebuilt from the carry terms: s_i = a_i ^ b_i ^ xor(group).
  function automatic logic [2:0] fold(input logic [24:0] n, input logic [3:0] a,
                                      input logic [3:0] b);
    fold[0] = a[1] ^ b[1] ^ (^n[2:0]);
    fold[1] = a[2] ^ b[2] ^ (^n[9:3]);
    fold[2] = a[3] ^ b[3] ^ (^n[24:10]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    lat          = 0;
    do begin
      tick();
      lat++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 4'hF;
    bus.b        = 4'hF;
    bus.cin      = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.n_out !== 25'h0) begin miscompares++; $display("FAIL reset_n_out got %h want 0", bus.n_out); end
    vectors++; if (bus.a_out !== 4'h0 || bus.b_out !== 4'h0) begin miscompares++; $display("FAIL reset_ab_out got %h/%h want 0/0", bus.a_out, bus.b_out); end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_no_accept in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    run_op(4'h1, 4'h1, 1'b0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL basic_latency got %0d want 4", lat); end
    vectors++; if (bus.n_out !== 25'h0000001) begin miscompares++; $display("FAIL basic_n_out got %h want 0000001", bus.n_out); end
    vectors++; if (bus.a_out !== 4'h1 || bus.b_out !== 4'h1) begin miscompares++; $display("FAIL basic_ab_out got %h/%h want 1/1", bus.a_out, bus.b_out); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_done got %b want 0", bus.in_ready); end
    release_result();
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_release got ov=%b ir=%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_carry();
    int lat;
    logic [24:0] exp_n;
    exp_n = CIN_EN ? 25'h0000077 : 25'h0000011;
    run_op(4'h3, 4'h1, 1'b1, lat);
    vectors++; if (bus.n_out !== exp_n) begin miscompares++; $display("FAIL carry_n_out got %h want %h", bus.n_out, exp_n); end
    vectors++; if (fold(bus.n_out, 4'h3, 4'h1) !== 3'b010) begin miscompares++; $display("FAIL carry_fold got %b want 010", fold(bus.n_out, 4'h3, 4'h1)); end
    release_result();
  endtask

  task automatic test_all_ones();
    int lat;
    logic [24:0] exp_n;
    exp_n = CIN_EN ? 25'h1FFFFFF : 25'h04C9C99;
    run_op(4'hF, 4'hF, 1'b1, lat);
    vectors++; if (bus.n_out !== exp_n) begin miscompares++; $display("FAIL ones_n_out got %h want %h", bus.n_out, exp_n); end
    vectors++; if (fold(bus.n_out, 4'hF, 4'hF) !== 3'b111) begin miscompares++; $display("FAIL ones_fold got %b want 111", fold(bus.n_out, 4'hF, 4'hF)); end
    release_result();
  endtask

  task automatic test_stall();
    int lat;
    run_op(4'h5, 4'h6, 1'b0, lat);
    vectors++; if (bus.n_out !== 25'h0000400) begin miscompares++; $display("FAIL stall_first_n got %h want 0000400", bus.n_out); end
    bus.a        = 4'h9;
    bus.b        = 4'h3;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.n_out !== 25'h0000400 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.a_out !== 4'h5) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d got n=%h ov=%b ir=%b a=%h want 0000400/1/0/5",
                 i, bus.n_out, bus.out_valid, bus.in_ready, bus.a_out);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_exit got ov=%b ir=%b want 0/1", bus.out_valid, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.in_ready !== 1'b0 || bus.a_out !== 4'h9) begin miscompares++; $display("FAIL stall_second_accept got ir=%b a=%h want 0/9", bus.in_ready, bus.a_out); end
    lat = 1;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL stall_second_latency got %0d want 4", lat); end
    vectors++; if (bus.n_out !== 25'h0000081) begin miscompares++; $display("FAIL stall_second_n got %h want 0000081", bus.n_out); end
    release_result();
  endtask

  task automatic test_reset_abort();
    int lat;
    bus.a = 4'hF; bus.b = 4'hF; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.n_out !== 25'h0 || bus.in_ready !== 1'b1 || bus.a_out !== 4'h0) begin
      miscompares++;
      $display("FAIL abort_state got ov=%b n=%h ir=%b a=%h want 0/0/1/0",
               bus.out_valid, bus.n_out, bus.in_ready, bus.a_out);
    end
    run_op(4'h2, 4'h7, 1'b0, lat);
    vectors++; if (lat !== 4 || bus.n_out !== 25'h0040008) begin miscompares++; $display("FAIL abort_next got lat=%0d n=%h want 4/0040008", lat, bus.n_out); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic hs;
    first  = -1;
    second = -1;
    bus.a = 4'h7; bus.b = 4'h5; bus.cin = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      hs = bus.in_valid & bus.in_ready;
      tick();
      if (hs) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++; if (first !== 0 || second !== 5) begin miscompares++; $display("FAIL b2b_period got %0d/%0d want 0/5", first, second); end
    vectors++; if (bus.in_ready !== 1'b1 || bus.n_out !== 25'h0081411) begin miscompares++; $display("FAIL b2b_result got ir=%b n=%h want 1/0081411", bus.in_ready, bus.n_out); end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] sum;
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 1'($urandom_range(1));
      sum = 5'(ra) + 5'(rb) + 5'(rc & CIN_EN);
      run_op(ra, rb, rc, lat);
      vectors++;
      if (lat !== 4 || fold(bus.n_out, ra, rb) !== sum[3:1] || bus.a_out !== ra || bus.b_out !== rb) begin
        miscompares++;
        $display("FAIL random %0d a=%h b=%h c=%b got lat=%0d fold=%b a=%h b=%h want 4/%b/%h/%h",
                 i, ra, rb, rc, lat, fold(bus.n_out, ra, rb), bus.a_out, bus.b_out, sum[3:1], ra, rb);
      end
      release_result();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 4'h0;
    bus.b         = 4'h0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_all_ones();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gen_nonlinear_seq.md
GEN_NONLINEAR_SEQ -- requirements
Module: gen_nonlinear_seq

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk input 1 (rising edge), rst input 1 (synchronous, active-high).
REQ-002 in_valid input 1: operand set offered.
REQ-003 in_ready output 1: block accepts operands this cycle.
REQ-004 a input 4: adder operand A.
REQ-005 b input 4: adder operand B.
REQ-006 cin input 1: carry-in.
REQ-007 out_valid output 1: n_out, a_out and b_out are complete and stable.
REQ-008 out_ready input 1: downstream linear stage consumes the result.
REQ-009 n_out output 25: non-linear carry terms, in the order the linear stage XOR-folds them.
REQ-010 a_out, b_out output 4 each: captured operands, forwarded to the linear stage.

Function
REQ-011 The block SHALL implement the FSM IDLE -> G1 -> G2 -> G3 -> DONE -> IDLE, advancing one state per clk.
REQ-012 in_ready SHALL be 1 only in IDLE; a handshake (in_valid & in_ready) SHALL capture a, b and cin and move the FSM to G1.
REQ-013 G1 SHALL write n[2:0] = {b0&cin, a0&cin, a0&b0}, with n[0] = a0&b0.
REQ-014 G2 SHALL write n[3] = a1&b1, n[6:4] = a1&n[2:0] and n[9:7] = b1&n[2:0].
REQ-015 G3 SHALL write n[10] = a2&b2, n[17:11] = a2&n[9:3] and n[24:18] = b2&n[9:3].
REQ-016 Each group SHALL use only register values from the previous group; there is no combinational path from a, b or cin to n_out.
REQ-017 out_valid SHALL be 1 only in DONE, so it rises 4 cycles after the accepting edge.
REQ-018 DONE SHALL hold n_out, a_out and b_out stable until out_ready=1, then go to IDLE on the next edge.
REQ-019 Back-to-back throughput SHALL be one operand set per 5 cycles minimum; no new operand set is accepted while busy.
REQ-020 On a new acceptance, all n bits SHALL be cleared before G1, so no stale terms remain.
REQ-021 The XOR of each n group with a_i^b_i SHALL equal bit i of a+b+cin (i = 1..3); bit 0 is handled downstream.

Reset
REQ-022 While rst=1 at a clk edge: FSM SHALL go to IDLE; n_out = 25'h0, a_out = b_out = 4'h0, out_valid = 0 and in_ready = 1 on the following cycle.
REQ-023 Reset asserted in any of G1..DONE SHALL abort the operation with no partial result presented.
REQ-024 in_valid asserted during rst SHALL NOT be accepted.

Configuration
REQ-025 With macro GEN_NL_CARRY_IN_EN defined, cin SHALL be captured and used per REQ-013.
REQ-026 Without GEN_NL_CARRY_IN_EN, the cin port SHALL remain present but be ignored: captured carry = 0, so n[1] = n[2] = 0 and the dependent terms follow.

Structure
REQ-027 A shared package SHALL hold: NL_W = 25, group offsets NL_G1_OFF = 0, NL_G2_OFF = 3, NL_G3_OFF = 10, group widths 3/7/15, and the FSM state enum.
REQ-028 The per-group product logic SHALL be one sub-module, gen_nl_group, parameterised by input width.
REQ-029 gen_nl_group inputs SHALL be: a_i, b_i and the previous group vector; its output SHALL be {b_i&prev, a_i&prev, a_i&b_i}.
REQ-030 G1 SHALL use gen_nl_group with prev = cin.

Verification
REQ-031 a=4'h1, b=4'h1, cin=0 -> out_valid 4 cycles after accept; n_out = 25'h0000001.
REQ-032 a=4'h3, b=4'h1, cin=1 (GEN_NL_CARRY_IN_EN) -> n_out = 25'h0000077; linear fold gives s[3:1] = 3'b010.
REQ-033 a=4'hF, b=4'hF, cin=1 -> n_out = 25'h1FFFFFF; without GEN_NL_CARRY_IN_EN -> n[1] = n[2] = 0 and s[3:1] = 3'b111.
REQ-034 Result in DONE with out_ready=0 for 6 cycles, and in_valid held high with new operands -> n_out stable, in_ready = 0, second operand set accepted only after the out_ready handshake.
REQ-035 rst pulsed during G2 -> next cycle IDLE, out_valid = 0, n_out = 0; a following operand set completes correctly.
REQ-036 Randomised check: 1000 random a, b, cin -> linear fold of n_out matches (a+b+cin)[3:1] for every result.
